// File: rtl/mc_ctrl_pkg.sv
// Shared types and constants for the multicycle ARM-subset controller:
// FSM state enum, ALU op codes, condition codes, mux encodings and the
// condition-code evaluation helper.
package mc_ctrl_pkg;

    typedef enum logic [3:0] {
        sFetch, sDecode, sMemAdr, sMemRead, sMemWb,
        sMemWrite, sExecR, sExecI, sAluWb, sBranch
    } state_t;

    // ALU operations (sized to the widest supported ALUControl)
    localparam logic [2:0] aluAdd = 3'd0;
    localparam logic [2:0] aluSub = 3'd1;
    localparam logic [2:0] aluAnd = 3'd2;
    localparam logic [2:0] aluOrr = 3'd3;
    localparam logic [2:0] aluEor = 3'd4;

    // ARM condition field
    localparam logic [3:0] condEq = 4'b0000;
    localparam logic [3:0] condNe = 4'b0001;
    localparam logic [3:0] condCs = 4'b0010;
    localparam logic [3:0] condCc = 4'b0011;
    localparam logic [3:0] condMi = 4'b0100;
    localparam logic [3:0] condPl = 4'b0101;
    localparam logic [3:0] condVs = 4'b0110;
    localparam logic [3:0] condVc = 4'b0111;
    localparam logic [3:0] condHi = 4'b1000;
    localparam logic [3:0] condLs = 4'b1001;
    localparam logic [3:0] condGe = 4'b1010;
    localparam logic [3:0] condLt = 4'b1011;
    localparam logic [3:0] condGt = 4'b1100;
    localparam logic [3:0] condLe = 4'b1101;
    localparam logic [3:0] condAl = 4'b1110;

    // Datapath mux encodings
    localparam logic [1:0] srcARn      = 2'b00;
    localparam logic [1:0] srcAPc      = 2'b01;
    localparam logic [1:0] srcBRm      = 2'b00;
    localparam logic [1:0] srcBImm     = 2'b01;
    localparam logic [1:0] srcBFour    = 2'b10;
    localparam logic [1:0] resAluOut   = 2'b00;
    localparam logic [1:0] resData     = 2'b01;
    localparam logic [1:0] resAluRes   = 2'b10;

    // Evaluate an ARM condition against {N,Z,C,V}; 1111 never executes.
    function automatic logic condHolds(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, r;
        {n, z, c, v} = nzcv;
        case (cond)
            condEq:  r = z;
            condNe:  r = ~z;
            condCs:  r = c;
            condCc:  r = ~c;
            condMi:  r = n;
            condPl:  r = ~n;
            condVs:  r = v;
            condVc:  r = ~v;
            condHi:  r = c & ~z;
            condLs:  r = ~c | z;
            condGe:  r = (n == v);
            condLt:  r = (n != v);
            condGt:  r = ~z & (n == v);
            condLe:  r = z | (n != v);
            condAl:  r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_cond_check.sv
// NZCV flags register, flag-write gating and condition evaluation.
// CondEx is captured once per instruction (at DECODE) so that the
// write-back of the same instruction sees pre-update flags.
module mc_cond_check
    import mc_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cond,
    input  logic [3:0] aluFlags,
    input  logic       latchCond,
    input  logic       flagWrite,
    input  logic       cvWrite,
    output logic       condEx
);
    logic [3:0] flags;
    logic       condLive;

    // Condition evaluated against the currently registered flags
    always_comb condLive = condHolds(cond, flags);

    // Latch CondEx at DECODE; update flags at end of EXECUTE when executed
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags  <= 4'b0000;
            condEx <= 1'b0;
        end else begin
            if (latchCond) condEx <= condLive;
            if (flagWrite && condEx) begin
                flags[3:2] <= aluFlags[3:2];
                if (cvWrite) flags[1:0] <= aluFlags[1:0];
            end
        end
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle control unit: instruction decoder, main FSM and Moore output
// logic. Optional feature macro: MC_CTRL_CMP_EN (decode cmd 1010 as CMP).
module mc_controller
    import mc_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:12]         Instr,
    input  logic [3:0]           ALUFlags,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 IRWrite,
    output logic                 AdrSrc,
    output logic [1:0]           RegSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl
);
    state_t     state;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic       rdIsPc;
    logic [2:0] dpOp;
    logic       dpValid, isCmp, undef, sBit, cvWrite, condEx;
    logic [2:0] aluSel;
    logic       unusedRn;

    assign op       = Instr[27:26];
    assign funct    = Instr[25:20];
    assign cmd      = funct[4:1];
    assign rdIsPc   = (Instr[15:12] == 4'b1111);
    assign unusedRn = &{1'b0, Instr[19:16]};

    // Data-processing command decode and undefined-instruction detection
    always_comb begin
        dpOp    = aluAdd;
        dpValid = 1'b0;
        isCmp   = 1'b0;
        case (cmd)
            4'b0100: begin dpOp = aluAdd; dpValid = 1'b1; end
            4'b0010: begin dpOp = aluSub; dpValid = 1'b1; end
            4'b0000: begin dpOp = aluAnd; dpValid = 1'b1; end
            4'b1100: begin dpOp = aluOrr; dpValid = 1'b1; end
            4'b0001: begin
                dpOp    = aluEor;
                dpValid = (ALUCTRL_W >= 3);
            end
`ifdef MC_CTRL_CMP_EN
            4'b1010: begin dpOp = aluSub; dpValid = 1'b1; isCmp = 1'b1; end
`else
`endif
            default: ;
        endcase
        undef   = (op == 2'b11) || (op == 2'b00 && !dpValid) || (op == 2'b01 && funct[5]);
        sBit    = funct[0] | isCmp;
        cvWrite = (dpOp == aluAdd) || (dpOp == aluSub);
    end

    mc_cond_check uCond (
        .clk       (clk),
        .reset     (reset),
        .cond      (Instr[31:28]),
        .aluFlags  (ALUFlags),
        .latchCond (state == sDecode),
        .flagWrite ((state == sExecR || state == sExecI) && sBit),
        .cvWrite   (cvWrite),
        .condEx    (condEx)
    );

    // Main FSM; memory states stall on mem_ready
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= sFetch;
        end else begin
            case (state)
                sFetch:    if (mem_ready) state <= sDecode;
                sDecode: begin
                    if (undef)              state <= sFetch;
                    else if (op == 2'b01)   state <= sMemAdr;
                    else if (op == 2'b00)   state <= funct[5] ? sExecI : sExecR;
                    else                    state <= sBranch;
                end
                sMemAdr:   state <= funct[0] ? sMemRead : sMemWrite;
                sMemRead:  if (mem_ready) state <= sMemWb;
                sMemWrite: if (mem_ready) state <= sFetch;
                sExecR,
                sExecI:    state <= sAluWb;
                default:   state <= sFetch;
            endcase
        end
    end

    // Moore outputs from state plus Instr/CondEx; all forced low in reset
    always_comb begin
        PCWrite   = 1'b0;
        MemWrite  = 1'b0;
        RegWrite  = 1'b0;
        IRWrite   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = srcARn;
        ALUSrcB   = srcBRm;
        ResultSrc = resAluOut;
        aluSel    = aluAdd;
        ImmSrc    = op;
        RegSrc    = {op == 2'b01, op == 2'b10};
        case (state)
            sFetch: begin
                ALUSrcA   = srcAPc;
                ALUSrcB   = srcBFour;
                ResultSrc = resAluRes;
                IRWrite   = mem_ready;
                PCWrite   = mem_ready;
            end
            sDecode: begin
                ALUSrcA   = srcAPc;
                ALUSrcB   = srcBFour;
                ResultSrc = resAluRes;
            end
            sMemAdr:   ALUSrcB = srcBImm;
            sMemRead:  AdrSrc  = 1'b1;
            sMemWb: begin
                ResultSrc = resData;
                RegWrite  = condEx;
                PCWrite   = condEx & rdIsPc;
            end
            sMemWrite: begin
                AdrSrc   = 1'b1;
                MemWrite = condEx;
            end
            sExecR:    aluSel = dpOp;
            sExecI: begin
                ALUSrcB = srcBImm;
                aluSel  = dpOp;
            end
            sAluWb: begin
                RegWrite = condEx & ~isCmp;
                PCWrite  = condEx & ~isCmp & rdIsPc;
            end
            sBranch: begin
                ALUSrcB   = srcBImm;
                ResultSrc = resAluRes;
                PCWrite   = condEx;
            end
            default: ;
        endcase
        if (!reset) begin
            PCWrite   = 1'b0;
            MemWrite  = 1'b0;
            RegWrite  = 1'b0;
            IRWrite   = 1'b0;
            AdrSrc    = 1'b0;
            ALUSrcA   = 2'b00;
            ALUSrcB   = 2'b00;
            ResultSrc = 2'b00;
            ImmSrc    = 2'b00;
            RegSrc    = 2'b00;
            aluSel    = 3'd0;
        end
    end

    assign ALUControl = ALUCTRL_W'(aluSel);

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: directed test-plan scenarios then
// random instructions, checked cycle by cycle against an instruction-level
// reference model (ARM condition rules + per-instruction step lists).
module tb_mc_controller;
    localparam int ALUCTRL_W = 2;
`ifdef MC_CTRL_CMP_EN
    localparam bit CmpEn = 1'b1;
`else
    localparam bit CmpEn = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 reset;
    logic [31:12]         Instr;
    logic [3:0]           ALUFlags;
    logic                 mem_ready;
    logic                 PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
    logic [1:0]           RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic [ALUCTRL_W-1:0] ALUControl;

    mc_controller #(.ALUCTRL_W(ALUCTRL_W)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags),
        .mem_ready(mem_ready), .PCWrite(PCWrite), .MemWrite(MemWrite),
        .RegWrite(RegWrite), .IRWrite(IRWrite), .AdrSrc(AdrSrc),
        .RegSrc(RegSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ResultSrc(ResultSrc), .ImmSrc(ImmSrc), .ALUControl(ALUControl)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pcw, mw, rw, irw, adr;
        logic [1:0] regSrc, srcA, srcB, resSrc, immSrc;
        logic [2:0] aluc;
    } ov_t;

    typedef struct {
        ov_t v;
        bit  fetch;
        bit  memStep;
        int  waits;
    } step_t;

    step_t      steps[$];
    logic [3:0] mFlags;
    logic [3:0] pendFlags;
    int         compared = 0;
    int         mism = 0;
    int         instrNo = 0;

    // ARM condition rules: base test selected by cond[3:1], inverted by cond[0]
    function automatic bit condPass(input logic [3:0] c, input logic [3:0] f);
        bit n, z, cc, v, r;
        {n, z, cc, v} = f;
        if (c == 4'hF) return 1'b0;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cc;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cc && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        return r ^ c[0];
    endfunction

    // ALU op for a DP cmd, or -1 when the cmd is unsupported
    function automatic int aluOpOf(input logic [3:0] cmd);
        case (cmd)
            4'b0100: return 0;
            4'b0010: return 1;
            4'b0000: return 2;
            4'b1100: return 3;
            4'b0001: return (ALUCTRL_W == 3) ? 4 : -1;
            4'b1010: return CmpEn ? 1 : -1;
            default: return -1;
        endcase
    endfunction

    function automatic logic [31:12] dp(input logic [3:0] c, input bit i, input logic [3:0] cmd,
                                        input bit s, input logic [3:0] rd);
        return {c, 2'b00, i, cmd, s, 4'h2, rd};
    endfunction

    function automatic logic [31:12] mem(input logic [3:0] c, input bit l, input logic [3:0] rd);
        return {c, 2'b01, 1'b0, 4'b1100, l, 4'h1, rd};
    endfunction

    function automatic logic [31:12] br(input logic [3:0] c);
        return {c, 2'b10, 14'h2A5C};
    endfunction

    // Expand one instruction into its expected per-step outputs
    task automatic buildSteps(input logic [31:12] ins, input logic [3:0] fl, input int fw, input int mw);
        logic [1:0] op;
        logic [5:0] funct;
        bit         ce, isCmp, rdPc, undef;
        int         aop;
        ov_t        b, s;
        op    = ins[27:26];
        funct = ins[25:20];
        rdPc  = (ins[15:12] == 4'hF);
        ce    = condPass(ins[31:28], mFlags);
        aop   = aluOpOf(funct[4:1]);
        isCmp = CmpEn && (funct[4:1] == 4'b1010);
        undef = (op == 2'b11) || (op == 2'b00 && aop < 0) || (op == 2'b01 && funct[5]);
        pendFlags = mFlags;
        steps.delete();
        b = '0;
        b.immSrc = op;
        b.regSrc = {op == 2'b01, op == 2'b10};
        s = b; s.srcA = 2'b01; s.srcB = 2'b10; s.resSrc = 2'b10; s.pcw = 1; s.irw = 1;
        steps.push_back('{s, 1, 1, fw});
        s = b; s.srcA = 2'b01; s.srcB = 2'b10; s.resSrc = 2'b10;
        steps.push_back('{s, 0, 0, 0});
        if (undef) return;
        if (op == 2'b00) begin
            s = b; s.srcB = funct[5] ? 2'b01 : 2'b00; s.aluc = 3'(aop);
            steps.push_back('{s, 0, 0, 0});
            s = b; s.rw = ce && !isCmp; s.pcw = ce && !isCmp && rdPc;
            steps.push_back('{s, 0, 0, 0});
            if (ce && (funct[0] || isCmp)) begin
                pendFlags[3:2] = fl[3:2];
                if (aop <= 1) pendFlags[1:0] = fl[1:0];
            end
        end else if (op == 2'b01) begin
            s = b; s.srcB = 2'b01;
            steps.push_back('{s, 0, 0, 0});
            if (funct[0]) begin
                s = b; s.adr = 1;
                steps.push_back('{s, 0, 1, mw});
                s = b; s.resSrc = 2'b01; s.rw = ce; s.pcw = ce && rdPc;
                steps.push_back('{s, 0, 0, 0});
            end else begin
                s = b; s.adr = 1; s.mw = ce;
                steps.push_back('{s, 0, 1, mw});
            end
        end else begin
            s = b; s.srcB = 2'b01; s.resSrc = 2'b10; s.pcw = ce;
            steps.push_back('{s, 0, 0, 0});
        end
    endtask

    task automatic check(input string tag, input ov_t exp);
        ov_t obs;
        obs = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc, ALUSrcA,
               ALUSrcB, ResultSrc, ImmSrc, 3'(ALUControl)};
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Run one instruction; abortStep >= 0 pulls reset during that step
    task automatic runInstr(input logic [31:12] ins, input logic [3:0] fl,
                            input int fw, input int mw, input int abortStep);
        ov_t e;
        buildSteps(ins, fl, fw, mw);
        instrNo++;
        for (int i = 0; i < steps.size(); i++) begin
            for (int k = 0; k <= steps[i].waits; k++) begin
                @(negedge clk);
                Instr    = ins;
                ALUFlags = fl;
                mem_ready = steps[i].memStep ? (k == steps[i].waits) : 1'($urandom);
                e = steps[i].v;
                if (steps[i].fetch && !mem_ready) begin e.pcw = 0; e.irw = 0; end
                #1 check($sformatf("i%0d_s%0d_c%0d", instrNo, i, k), e);
                if (i == abortStep) begin
                    reset = 1'b0;
                    #1 check("reset_abort_outputs", '0);
                    mem_ready = 1'b0;
                    @(negedge clk);
                    #1 check("reset_held_outputs", '0);
                    reset = 1'b1;
                    e = steps[0].v; e.pcw = 0; e.irw = 0;
                    #1 check("reset_release_fetch", e);
                    mFlags = 4'b0000;
                    return;
                end
            end
        end
        mFlags = pendFlags;
    endtask

    initial begin
        logic [31:0] r;
        logic [31:12] ins;
        logic [3:0] cmdList [6];
        cmdList = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1010, 4'b0001};
        reset = 1'b0; Instr = '0; ALUFlags = '0; mem_ready = 1'b1; mFlags = 4'b0000;
        repeat (2) @(negedge clk);
        #1 check("reset_outputs_zero", '0);
        mem_ready = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // ADD imm, AL
        runInstr(dp(4'hE, 1, 4'b0100, 0, 4'h3), 4'b1111, 0, 0, -1);
        // SUBS reg with Z, then BEQ taken, SUBS again, BNE not taken
        runInstr(dp(4'hE, 0, 4'b0010, 1, 4'h2), 4'b0100, 0, 0, -1);
        runInstr(br(4'h0), 4'b0000, 0, 0, -1);
        runInstr(dp(4'hE, 0, 4'b0010, 1, 4'h2), 4'b0100, 0, 0, -1);
        runInstr(br(4'h1), 4'b0000, 1, 0, -1);
        // LDR with two wait cycles in MEMREAD, then STR held for two cycles
        runInstr(mem(4'hE, 1, 4'h4), 4'b0000, 0, 2, -1);
        runInstr(mem(4'hE, 0, 4'h5), 4'b0000, 1, 2, -1);
        // ORR writing PC
        runInstr(dp(4'hE, 0, 4'b1100, 0, 4'hF), 4'b0000, 0, 0, -1);
        // CMP, then BMI exposes whether N was updated
        runInstr(dp(4'hE, 0, 4'b1010, 0, 4'h1), 4'b1001, 0, 0, -1);
        runInstr(br(4'h4), 4'b0000, 0, 0, -1);
        // Set Z, abort a STR with reset in MEMWRITE, then BNE sees cleared flags
        runInstr(dp(4'hE, 0, 4'b0010, 1, 4'h2), 4'b0100, 0, 0, -1);
        runInstr(mem(4'hE, 0, 4'h6), 4'b0000, 0, 3, 3);
        runInstr(br(4'h1), 4'b0000, 0, 0, -1);
        runInstr(br(4'hF), 4'b0000, 0, 0, -1);

        // Random instruction mix
        for (int n = 0; n < 300; n++) begin
            r = $urandom;
            case (r[3:0] % 10)
                0, 1, 2, 3: ins = dp(r[6:4] == 0 ? 4'hE : r[11:8], r[12], cmdList[r[15:13] % 6],
                                     r[16], r[18:17] == 0 ? 4'hF : r[22:19]);
                4, 5:       begin ins = mem(r[11:8], r[12], r[22:19]); ins[25] = (r[25:23] == 0); end
                6, 7:       ins = br(r[11:8]);
                8:          begin ins = r[31:12]; ins[27:26] = 2'b11; end
                default:    ins = r[31:12] ^ 20'($urandom);
            endcase
            runInstr(ins, 4'($urandom), $urandom_range(0, 2), $urandom_range(0, 2), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
